// File: rtl/dog_if.sv
// dog_if: DoG sample stream in, keypoint candidates and frame marker out
interface dog_if;
   logic        in_valid;
   logic [20:0] in_addr;
   logic [7:0]  diff0;
   logic [7:0]  diff1;
   logic [7:0]  diff2;
   logic        kp_valid;
   logic [10:0] kp_x;
   logic [10:0] kp_y;
   logic        kp_is_max;
   logic [7:0]  kp_value;
   logic        frame_done;
   modport master (
      output in_valid, in_addr, diff0, diff1, diff2,
      input  kp_valid, kp_x, kp_y, kp_is_max, kp_value, frame_done
   );
   modport slave (
      input  in_valid, in_addr, diff0, diff1, diff2,
      output kp_valid, kp_x, kp_y, kp_is_max, kp_value, frame_done
   );
endinterface

// File: rtl/dog_extrema_detect.sv
// dog_extrema_detect: 26-neighbour scale-space extremum detector over a 3x3x3 DoG window
module dog_extrema_detect #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int THRESH = 3
) (
   input logic clk,
   input logic rst,
   dog_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
   localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);
   logic              armed, sof, accept, kp_hit;
   logic [10:0]       col, row, cur_col, cur_row;
   logic [CW-1:0]     idx;
   logic signed [7:0] d [3];
   logic signed [7:0] lb0 [3][IMG_W];
   logic signed [7:0] lb1 [3][IMG_W];
   logic signed [7:0] w [3][3][3];
   logic              e_v, e_last, s1_v, s1_last;
   logic [10:0]       e_x, e_y, s1_x, s1_y;
   logic [26:0]       gt, lt, s1_gt, s1_lt;
   logic signed [7:0] s1_c;
   logic [8:0]        mag;
   assign sof     = bus.in_valid && bus.in_addr == '0;
   assign accept  = bus.in_valid && (sof || armed);
   assign cur_col = sof ? '0 : col;
   assign cur_row = sof ? '0 : row;
   assign idx     = cur_col[CW-1:0];
   assign d[0]    = bus.diff0;
   assign d[1]    = bus.diff1;
   assign d[2]    = bus.diff2;
   assign mag     = s1_c[7] ? 9'(-{s1_c[7], s1_c}) : {1'b0, s1_c};
   assign kp_hit  = s1_v && (&s1_gt || &s1_lt) && mag >= 9'(THRESH);
   // w[layer][column][row]: column 2 is the newest, row 0 the oldest line
   always_ff @(posedge clk)
      if (accept)
         for (int l = 0; l < 3; l++) begin
            lb1[l][idx] <= lb0[l][idx];
            lb0[l][idx] <= d[l];
            for (int r = 0; r < 3; r++) begin
               w[l][0][r] <= w[l][1][r];
               w[l][1][r] <= w[l][2][r];
            end
            w[l][2][0] <= lb1[l][idx];
            w[l][2][1] <= lb0[l][idx];
            w[l][2][2] <= d[l];
         end
   always_comb begin
      gt = '0;
      lt = '0;
      for (int l = 0; l < 3; l++)
         for (int k = 0; k < 3; k++)
            for (int r = 0; r < 3; r++) begin
               gt[l*9+r*3+k] = w[l][k][r] < w[1][1][1];
               lt[l*9+r*3+k] = w[1][1][1] < w[l][k][r];
            end
      gt[13] = 1'b1;
      lt[13] = 1'b1;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         armed          <= 1'b0;
         col            <= '0;
         row            <= '0;
         e_v            <= 1'b0;
         e_last         <= 1'b0;
         e_x            <= '0;
         e_y            <= '0;
         s1_v           <= 1'b0;
         s1_last        <= 1'b0;
         s1_gt          <= '0;
         s1_lt          <= '0;
         s1_c           <= '0;
         s1_x           <= '0;
         s1_y           <= '0;
         bus.kp_valid   <= 1'b0;
         bus.kp_x       <= '0;
         bus.kp_y       <= '0;
         bus.kp_is_max  <= 1'b0;
         bus.kp_value   <= '0;
         bus.frame_done <= 1'b0;
      end else begin
         if (accept) begin
            armed <= !(cur_col == X_LAST && cur_row == Y_LAST);
            col   <= cur_col == X_LAST ? '0 : cur_col + 11'd1;
            row   <= cur_col == X_LAST ? cur_row + 11'd1 : cur_row;
         end
         e_v            <= accept && cur_col >= 11'd2 && cur_row >= 11'd2;
         e_last         <= accept && cur_col == X_LAST && cur_row == Y_LAST;
         e_x            <= cur_col - 11'd1;
         e_y            <= cur_row - 11'd1;
         s1_v           <= e_v;
         s1_last        <= e_last;
         s1_gt          <= gt;
         s1_lt          <= lt;
         s1_c           <= w[1][1][1];
         s1_x           <= e_x;
         s1_y           <= e_y;
         bus.kp_valid   <= kp_hit;
         bus.frame_done <= s1_last;
         if (kp_hit) begin
            bus.kp_x      <= s1_x;
            bus.kp_y      <= s1_y;
            bus.kp_is_max <= &s1_gt;
            bus.kp_value  <= s1_c;
         end
      end
endmodule

// File: tb/tb_dog_extrema_detect.sv
// tb_dog_extrema_detect: directed frame vectors with hand-computed keypoints on an 8x6 image
module tb_dog_extrema_detect;
   localparam int W = 8;
   localparam int H = 6;
   typedef struct {
      int l1, x1, y1, v1;
      int l2, x2, y2, v2;
      int base, gap;
      int exp_n, ex, ey, emax, eval;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0, n_err = 0;
   int   kp_cnt = 0, fd_cnt = 0, kp_cyc = 0, fd_cyc = 0;
   int   lx = 0, ly = 0, lmax = 0, lval = 0;
   int   tgt_cyc = 0, last_cyc = 0, b_kp, b_fd;
   vec_t tv [11];
   dog_if bus ();
   dog_extrema_detect #(.IMG_W(W), .IMG_H(H), .THRESH(3)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bus.kp_valid) begin
         kp_cnt++;
         kp_cyc = cyc;
         lx     = int'(bus.kp_x);
         ly     = int'(bus.kp_y);
         lmax   = int'(bus.kp_is_max);
         lval   = int'($signed(bus.kp_value));
      end
      if (bus.frame_done) begin
         fd_cnt++;
         fd_cyc = cyc;
      end
   end
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   function automatic int pix(input vec_t v, input int l, input int x, input int y);
      if (l == v.l1 && x == v.x1 && y == v.y1) return v.v1;
      if (l == v.l2 && x == v.x2 && y == v.y2) return v.v2;
      return v.base;
   endfunction
   task automatic send(input vec_t v, input int a0, input int a1);
      for (int a = a0; a <= a1; a++) begin
         for (int g = 0; g < v.gap; g++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_addr  = 21'($urandom_range(0, 100));
            bus.diff0    = 8'($urandom);
            bus.diff1    = 8'($urandom);
            bus.diff2    = 8'($urandom);
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_addr  = 21'(a);
         bus.diff0    = 8'(pix(v, 0, a % W, a / W));
         bus.diff1    = 8'(pix(v, 1, a % W, a / W));
         bus.diff2    = 8'(pix(v, 2, a % W, a / W));
         if (a == (v.ey + 1) * W + v.ex + 1) tgt_cyc = cyc + 1;
         if (a == W * H - 1) last_cyc = cyc + 1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic junk(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_addr  = 21'($urandom_range(1, 100));
         bus.diff0    = 8'($urandom);
         bus.diff1    = 8'($urandom);
         bus.diff2    = 8'($urandom);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic chk_kp(input string nm, input vec_t v);
      chk({nm, " kp_x"}, lx, v.ex);
      chk({nm, " kp_y"}, ly, v.ey);
      chk({nm, " kp_is_max"}, lmax, v.emax);
      chk({nm, " kp_value"}, lval, v.eval);
   endtask
   initial begin
      tv[0]  = '{-1, 0, 0,    0, -1, 0, 0,   0,   5, 0, 0, 0, 0, 0,    0};
      tv[1]  = '{ 1, 3, 2,   40, -1, 0, 0,   0,   0, 0, 1, 3, 2, 1,   40};
      tv[2]  = '{ 1, 5, 4,  -20, -1, 0, 0,   0,   0, 0, 1, 5, 4, 0,  -20};
      tv[3]  = '{ 1, 5, 4,  -20,  2, 4, 3, -20,   0, 0, 0, 0, 0, 0,    0};
      tv[4]  = '{ 1, 2, 2,    2, -1, 0, 0,   0,   0, 0, 0, 0, 0, 0,    0};
      tv[5]  = '{ 1, 2, 2,    3, -1, 0, 0,   0,   0, 0, 1, 2, 2, 1,    3};
      tv[6]  = '{ 1, 3, 2,   40, -1, 0, 0,   0,   0, 3, 1, 3, 2, 1,   40};
      tv[7]  = '{ 1, 1, 1, -128, -1, 0, 0,   0,   0, 0, 1, 1, 1, 0, -128};
      tv[8]  = '{ 1, 4, 2,   -5, -1, 0, 0,   0, -10, 1, 1, 4, 2, 1,   -5};
      tv[9]  = '{ 1, 7, 2,   40, -1, 0, 0,   0,   0, 0, 0, 0, 0, 0,    0};
      tv[10] = '{ 1, 6, 4,   50, -1, 0, 0,   0,   0, 2, 1, 6, 4, 1,   50};
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_addr  = '0;
      bus.diff0    = '0;
      bus.diff1    = '0;
      bus.diff2    = '0;
      repeat (3) @(negedge clk);
      chk("reset kp_valid", int'(bus.kp_valid), 0);
      chk("reset frame_done", int'(bus.frame_done), 0);
      chk("reset kp_x", int'(bus.kp_x), 0);
      chk("reset kp_y", int'(bus.kp_y), 0);
      chk("reset kp_is_max", int'(bus.kp_is_max), 0);
      chk("reset kp_value", int'(bus.kp_value), 0);
      rst = 1'b1;
      junk(5);
      for (int k = 0; k < 11; k++) begin
         b_kp = kp_cnt;
         b_fd = fd_cnt;
         send(tv[k], 0, W * H - 1);
         junk(4);
         repeat (4) @(negedge clk);
         chk($sformatf("v%0d kp_count", k), kp_cnt - b_kp, tv[k].exp_n);
         chk($sformatf("v%0d frame_done_count", k), fd_cnt - b_fd, 1);
         chk($sformatf("v%0d frame_done_latency", k), fd_cyc - last_cyc, 2);
         if (tv[k].exp_n == 1) begin
            chk_kp($sformatf("v%0d", k), tv[k]);
            chk($sformatf("v%0d kp_latency", k), kp_cyc - tgt_cyc, 2);
         end
      end
      b_kp = kp_cnt;
      b_fd = fd_cnt;
      send(tv[1], 0, 19);
      send(tv[1], 0, W * H - 1);
      repeat (5) @(negedge clk);
      chk("restart kp_count", kp_cnt - b_kp, 1);
      chk("restart frame_done_count", fd_cnt - b_fd, 1);
      chk("restart kp_latency", kp_cyc - tgt_cyc, 2);
      chk_kp("restart", tv[1]);
      b_kp = kp_cnt;
      b_fd = fd_cnt;
      send(tv[1], 0, 29);
      rst = 1'b0;
      #1;
      chk("midreset kp_valid", int'(bus.kp_valid), 0);
      chk("midreset kp_x", int'(bus.kp_x), 0);
      chk("midreset kp_y", int'(bus.kp_y), 0);
      chk("midreset kp_is_max", int'(bus.kp_is_max), 0);
      chk("midreset kp_value", int'(bus.kp_value), 0);
      chk("midreset frame_done", int'(bus.frame_done), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      send(tv[1], 30, W * H - 1);
      repeat (5) @(negedge clk);
      chk("postreset kp_count", kp_cnt - b_kp, 0);
      chk("postreset frame_done_count", fd_cnt - b_fd, 0);
      send(tv[1], 0, W * H - 1);
      repeat (5) @(negedge clk);
      chk("newframe kp_count", kp_cnt - b_kp, 1);
      chk("newframe frame_done_count", fd_cnt - b_fd, 1);
      chk_kp("newframe", tv[1]);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
